fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   IF stage of the 5-stage MIPS pipeline: holds the PC, drives the word address into the
//   1K-word instruction memory, and captures the returned instruction into the IF/ID register.
//   Handles hazard-unit stalls and branch/jump redirects from ID, which flush the fetched slot.
//   Sits directly upstream of the instruction memory and the decode stage.
// PARAMETERS
//   RESET_PC    32'h0000_0000  byte address loaded into pc on reset
//   IMEM_DEPTH  1024           instruction-memory depth in words (addr_oob flag only)
// PORTS
//   clk            in   1   clock; all state updates on posedge
//   rst            in   1   reset, asynchronous, active-low
//   stall          in   1   hazard unit: hold pc and IF/ID contents
//   redirect       in   1   ID resolved taken branch/jump; load redirect_pc, flush IF/ID
//   redirect_pc    in   32  target byte address
//   imem_instr     in   32  instruction from memory (combinational read of imem_addr)
//   imem_addr      out  32  word index into instruction memory = {2'b00, pc[31:2]}
//   pc             out  32  current fetch byte address
//   addr_oob       out  1   pc[31:2] >= IMEM_DEPTH (combinational)
//   if_id_instr    out  32  registered instruction for ID
//   if_id_pc_plus4 out  32  registered pc+4 of that instruction
//   if_id_valid    out  1   1 = if_id_instr is a real fetched instruction
// BEHAVIOUR
//   - Reset (rst=0, async): pc=RESET_PC, if_id_instr=NOP (32'h0), if_id_pc_plus4=0,
//     if_id_valid=0; counters (if enabled) = 0. First fetch is in the cycle rst deasserts.
//   - imem_addr, addr_oob are combinational from pc; instruction memory returns imem_instr
//     in the same cycle, so fetch-to-IF/ID latency is 1 clock.
//   - Per posedge, priority redirect > stall > normal:
//       redirect=1:  pc <= {redirect_pc[31:2],2'b00} (low bits forced 0);
//                    IF/ID <= bubble (instr=NOP, pc_plus4=0, valid=0). stall ignored.
//       stall=1:     pc, if_id_* hold their values.
//       otherwise:   pc <= pc+4; if_id_instr <= imem_instr; if_id_pc_plus4 <= pc+4;
//                    if_id_valid <= 1.
//   - pc+4 is 32-bit modulo: 32'hFFFF_FFFC -> 32'h0000_0000, no flag.
//   - addr_oob does not alter fetch; memory behaviour past IMEM_DEPTH is its own concern.
//   - No delay slot: the instruction fetched in the redirect cycle is always discarded.
//   - Reset asserted mid-stall or mid-redirect: reset values win immediately.
// CONFIGURATION
//   FETCH_STATS_EN defined: adds outputs fetch_count[31:0] (+1 per cycle IF/ID loads a valid
//     instr), stall_count[31:0] (+1 per cycle with stall=1 and redirect=0),
//     flush_count[31:0] (+1 per redirect cycle). All saturate at 32'hFFFF_FFFF, reset to 0.
//   Not defined: those ports and counters do not exist; all other behaviour identical.
// STRUCTURE
//   Package fetch_pkg: XLEN=32, NOP_INSTR=32'h0000_0000, DEFAULT_RESET_PC, typedef
//     if_id_t {instr, pc_plus4, valid}.
//   One sub-module: if_id_register (load/hold/flush of if_id_t, async active-low reset).
//   PC register and next-pc mux live in fetch_stage.
// TESTING
//   1 Reset then 4 free cycles, imem returns 0x100+idx -> pc 0,4,8,12,16; if_id_instr
//     0x100..0x103, if_id_pc_plus4 4..16, valid=1 from cycle 1.
//   2 stall=1 for 3 cycles at pc=8 -> pc stays 8, IF/ID unchanged; release -> pc=12 next.
//   3 redirect=1, redirect_pc=0x40 at pc=0x10 -> pc=0x40, if_id_valid=0, instr=0; next
//     cycle fetches word 0x10.
//   4 redirect and stall both 1, redirect_pc=0x23 -> pc=0x20, IF/ID flushed.
//   5 pc forced near top: RESET_PC=32'hFFFF_FFFC -> next pc=0, imem_addr=0x3FFF_FFFF then 0,
//     addr_oob 1 then 0.
//   6 rst pulsed low mid-stall -> all outputs at reset values asynchronously; with
//     FETCH_STATS_EN, 5 fetches/2 stalls/1 flush -> counts 5/2/1, then cleared by reset.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the IF stage.
//   XLEN, NOP_INSTR, DEFAULT_RESET_PC, if_id_t {instr, pc_plus4, valid},
//   IF_ID_BUBBLE (flushed IF/ID contents) and a saturating counter increment.
package fetch_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc_plus4;
      logic            valid;
   } if_id_t;
   localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
   function automatic logic [XLEN-1:0] sat_inc(input logic [XLEN-1:0] v, input logic en);
      return (en && v != '1) ? v + 32'd1 : v;
   endfunction
endpackage

// File: rtl/if_id_register.sv
// if_id_register: IF/ID pipeline register with load, hold and flush.
//   clk, rst (async active-low), load (capture d), flush (insert bubble, beats load),
//   d (next contents), q (registered contents).
module if_id_register
   import fetch_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   load,
   input  logic   flush,
   input  if_id_t d,
   output if_id_t q
);
   if_id_t if_id_d, if_id_q;
   always_comb if_id_d = flush ? IF_ID_BUBBLE : load ? d : if_id_q;
   always_ff @(posedge clk or negedge rst)
      if (!rst) if_id_q <= IF_ID_BUBBLE;
      else      if_id_q <= if_id_d;
   assign q = if_id_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage - PC register, next-pc mux, imem addressing, IF/ID capture.
//   clk, rst (async active-low), stall (hold pc and IF/ID), redirect/redirect_pc (taken
//   branch/jump from ID, flushes IF/ID), imem_instr (combinational imem read data),
//   imem_addr (word index), pc, addr_oob (pc past IMEM_DEPTH), if_id_instr,
//   if_id_pc_plus4, if_id_valid.
//   FETCH_STATS_EN defined: adds saturating fetch_count, stall_count, flush_count outputs.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int              IMEM_DEPTH = 1024
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic [XLEN-1:0] imem_instr,
   output logic [XLEN-1:0] imem_addr,
   output logic [XLEN-1:0] pc,
   output logic            addr_oob,
   output logic [XLEN-1:0] if_id_instr,
   output logic [XLEN-1:0] if_id_pc_plus4,
   output logic            if_id_valid
`ifdef FETCH_STATS_EN
   ,
   output logic [XLEN-1:0] fetch_count,
   output logic [XLEN-1:0] stall_count,
   output logic [XLEN-1:0] flush_count
`endif
);
   logic [XLEN-1:0] pc_d, pc_q, pc_plus4;
   if_id_t if_id_in, if_id_out;
   assign pc_plus4 = pc_q + 32'd4;
   // redirect wins over stall; the slot fetched alongside a redirect is dropped
   always_comb pc_d = redirect ? {redirect_pc[XLEN-1:2], 2'b00} : stall ? pc_q : pc_plus4;
   always_ff @(posedge clk or negedge rst)
      if (!rst) pc_q <= RESET_PC;
      else      pc_q <= pc_d;
   assign pc        = pc_q;
   assign imem_addr = {2'b00, pc_q[XLEN-1:2]};
   assign addr_oob  = pc_q[XLEN-1:2] >= 30'(IMEM_DEPTH);
   assign if_id_in  = '{instr: imem_instr, pc_plus4: pc_plus4, valid: 1'b1};
   if_id_register u_if_id (
      .clk   (clk),
      .rst   (rst),
      .load  (!stall),
      .flush (redirect),
      .d     (if_id_in),
      .q     (if_id_out)
   );
   assign if_id_instr    = if_id_out.instr;
   assign if_id_pc_plus4 = if_id_out.pc_plus4;
   assign if_id_valid    = if_id_out.valid;
`ifdef FETCH_STATS_EN
   logic [XLEN-1:0] fetch_count_d, fetch_count_q;
   logic [XLEN-1:0] stall_count_d, stall_count_q;
   logic [XLEN-1:0] flush_count_d, flush_count_q;
   always_comb begin
      fetch_count_d = sat_inc(fetch_count_q, !redirect && !stall);
      stall_count_d = sat_inc(stall_count_q, stall && !redirect);
      flush_count_d = sat_inc(flush_count_q, redirect);
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         fetch_count_q <= '0;
         stall_count_q <= '0;
         flush_count_q <= '0;
      end else begin
         fetch_count_q <= fetch_count_d;
         stall_count_q <= stall_count_d;
         flush_count_q <= flush_count_d;
      end
   assign fetch_count = fetch_count_q;
   assign stall_count = stall_count_q;
   assign flush_count = flush_count_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage (optionally built with FETCH_STATS_EN).
module tb_fetch_stage;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pp4;
      logic        valid;
   } exp_t;

   logic        clk = 0, rst = 0, stall = 0, redirect = 0;
   logic [31:0] redirect_pc = 0;
   logic [31:0] imem_addr, imem_instr, pc, if_id_instr, if_id_pc_plus4;
   logic        addr_oob, if_id_valid;
   logic [31:0] imem_addr2, imem_instr2, pc2, if_id_instr2, if_id_pc_plus4_2;
   logic        addr_oob2, if_id_valid2;
`ifdef FETCH_STATS_EN
   logic [31:0] fetch_count, stall_count, flush_count, fc2, sc2, flc2;
`endif

   always #5 clk = ~clk;
   assign imem_instr  = 32'h100 + imem_addr;
   assign imem_instr2 = 32'h100 + imem_addr2;

   fetch_stage u_dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_instr(imem_instr), .imem_addr(imem_addr), .pc(pc), .addr_oob(addr_oob),
      .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid)
`ifdef FETCH_STATS_EN
      , .fetch_count(fetch_count), .stall_count(stall_count), .flush_count(flush_count)
`endif
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_top (
      .clk(clk), .rst(rst), .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
      .imem_instr(imem_instr2), .imem_addr(imem_addr2), .pc(pc2), .addr_oob(addr_oob2),
      .if_id_instr(if_id_instr2), .if_id_pc_plus4(if_id_pc_plus4_2), .if_id_valid(if_id_valid2)
`ifdef FETCH_STATS_EN
      , .fetch_count(fc2), .stall_count(sc2), .flush_count(flc2)
`endif
   );

   int checks = 0, passes = 0;
   exp_t sb[$];
   logic [31:0] m_pc, m_instr, m_pp4;
   logic        m_valid;

   task automatic model_reset();
      m_pc = 0; m_instr = 0; m_pp4 = 0; m_valid = 0;
      sb.delete();
   endtask

   // drive one cycle of stimulus, push the model's expected post-edge state
   task automatic drive(input logic st, input logic rd, input logic [31:0] rpc);
      stall = st; redirect = rd; redirect_pc = rpc;
      if (rd) begin
         m_pc = {rpc[31:2], 2'b00}; m_instr = 0; m_pp4 = 0; m_valid = 0;
      end else if (!st) begin
         m_instr = 32'h100 + (m_pc >> 2); m_pp4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
      end
      sb.push_back('{pc: m_pc, instr: m_instr, pp4: m_pp4, valid: m_valid});
      @(posedge clk); #1;
      stall = 0; redirect = 0;
   endtask

   task automatic test_reset();
      rst = 0;
      model_reset();
      @(posedge clk); #1;
      checks++;
      if ({pc, if_id_instr, if_id_pc_plus4, if_id_valid, imem_addr, addr_oob} !== {32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0})
         $display("FAIL reset: pc=%h instr=%h pp4=%h v=%b addr=%h oob=%b, want all 0", pc, if_id_instr, if_id_pc_plus4, if_id_valid, imem_addr, addr_oob);
      else passes++;
      rst = 1;
   endtask

   task automatic test_free_run();
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0);
         e = sb.pop_front();
         checks++;
         if ({pc, if_id_instr, if_id_pc_plus4, if_id_valid, imem_addr} !== {e.pc, e.instr, e.pp4, e.valid, e.pc >> 2})
            $display("FAIL free[%0d]: pc=%h instr=%h pp4=%h v=%b addr=%h, want pc=%h instr=%h pp4=%h v=%b", i, pc, if_id_instr, if_id_pc_plus4, if_id_valid, imem_addr, e.pc, e.instr, e.pp4, e.valid);
         else passes++;
      end
   endtask

   task automatic test_stall();
      exp_t e;
      logic [1:0] tbl [6] = '{2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00};
      for (int i = 0; i < 6; i++) begin
         drive(tbl[i][1], tbl[i][0], 32'h4);
         e = sb.pop_front();
         checks++;
         if ({pc, if_id_instr, if_id_pc_plus4, if_id_valid} !== {e.pc, e.instr, e.pp4, e.valid})
            $display("FAIL stall[%0d]: pc=%h instr=%h pp4=%h v=%b, want pc=%h instr=%h pp4=%h v=%b", i, pc, if_id_instr, if_id_pc_plus4, if_id_valid, e.pc, e.instr, e.pp4, e.valid);
         else passes++;
      end
   endtask

   task automatic test_redirect();
      exp_t e;
      logic tbl [3] = '{1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         drive(0, tbl[i], 32'h40);
         e = sb.pop_front();
         checks++;
         if ({pc, if_id_instr, if_id_pc_plus4, if_id_valid} !== {e.pc, e.instr, e.pp4, e.valid})
            $display("FAIL redirect[%0d]: pc=%h instr=%h pp4=%h v=%b, want pc=%h instr=%h pp4=%h v=%b", i, pc, if_id_instr, if_id_pc_plus4, if_id_valid, e.pc, e.instr, e.pp4, e.valid);
         else passes++;
      end
   endtask

   task automatic test_redirect_stall();
      exp_t e;
      drive(0, 0, 0);
      e = sb.pop_front();
      drive(1, 1, 32'h23);
      e = sb.pop_front();
      checks++;
      if ({pc, if_id_instr, if_id_pc_plus4, if_id_valid} !== {e.pc, e.instr, e.pp4, e.valid})
         $display("FAIL redirect_stall: pc=%h instr=%h pp4=%h v=%b, want pc=%h instr=%h pp4=%h v=%b", pc, if_id_instr, if_id_pc_plus4, if_id_valid, e.pc, e.instr, e.pp4, e.valid);
      else passes++;
   endtask

   task automatic test_oob();
      exp_t e;
      logic tbl [3] = '{1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 3; i++) begin
         drive(0, tbl[i], 32'hFFC);
         e = sb.pop_front();
         checks++;
         if ({pc, addr_oob, if_id_instr, if_id_valid} !== {e.pc, e.pc[31:2] >= 30'd1024, e.instr, e.valid})
            $display("FAIL oob[%0d]: pc=%h oob=%b instr=%h v=%b, want pc=%h oob=%b instr=%h v=%b", i, pc, addr_oob, if_id_instr, if_id_valid, e.pc, e.pc[31:2] >= 30'd1024, e.instr, e.valid);
         else passes++;
      end
   endtask

   task automatic test_wrap();
      exp_t e;
      #2 rst = 0;
      model_reset();
      #1;
      checks++;
      if ({pc2, imem_addr2, addr_oob2, if_id_valid2} !== {32'hFFFF_FFFC, 32'h3FFF_FFFF, 1'b1, 1'b0})
         $display("FAIL wrap_reset: pc=%h addr=%h oob=%b v=%b, want fffffffc 3fffffff 1 0", pc2, imem_addr2, addr_oob2, if_id_valid2);
      else passes++;
      @(posedge clk); #1;
      rst = 1;
      drive(0, 0, 0);
      e = sb.pop_front();
      checks++;
      if ({pc2, imem_addr2, addr_oob2, if_id_instr2, if_id_pc_plus4_2, if_id_valid2} !== {32'h0, 32'h0, 1'b0, 32'h4000_00FF, 32'h0, 1'b1})
         $display("FAIL wrap_next: pc=%h addr=%h oob=%b instr=%h pp4=%h v=%b, want 0 0 0 400000ff 0 1", pc2, imem_addr2, addr_oob2, if_id_instr2, if_id_pc_plus4_2, if_id_valid2);
      else passes++;
      checks++;
      if ({pc, if_id_instr, if_id_valid} !== {e.pc, e.instr, e.valid})
         $display("FAIL wrap_main: pc=%h instr=%h v=%b, want pc=%h instr=%h v=%b", pc, if_id_instr, if_id_valid, e.pc, e.instr, e.valid);
      else passes++;
   endtask

`ifdef FETCH_STATS_EN
   task automatic test_stats();
      exp_t e;
      logic [1:0] tbl [7] = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
      for (int i = 0; i < 7; i++) begin
         drive(tbl[i][1], tbl[i][0], 32'h80);
         e = sb.pop_front();
      end
      checks++;
      if ({fetch_count, stall_count, flush_count} !== {32'd5, 32'd2, 32'd1})
         $display("FAIL stats: fetch=%0d stall=%0d flush=%0d, want 5 2 1", fetch_count, stall_count, flush_count);
      else passes++;
   endtask
`endif

   task automatic test_async_reset();
      exp_t e;
      drive(0, 0, 0);
      e = sb.pop_front();
      stall = 1;
      @(posedge clk); #3;
      rst = 0;
      #1;
      checks++;
      if ({pc, if_id_instr, if_id_pc_plus4, if_id_valid, imem_addr, pc2, if_id_valid2} !== {32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b0})
         $display("FAIL async_reset: pc=%h instr=%h pp4=%h v=%b addr=%h pc2=%h v2=%b, want reset values", pc, if_id_instr, if_id_pc_plus4, if_id_valid, imem_addr, pc2, if_id_valid2);
      else passes++;
`ifdef FETCH_STATS_EN
      checks++;
      if ({fetch_count, stall_count, flush_count} !== 96'h0)
         $display("FAIL stats_reset: fetch=%0d stall=%0d flush=%0d, want 0 0 0", fetch_count, stall_count, flush_count);
      else passes++;
`endif
      stall = 0;
      model_reset();
      @(posedge clk); #1;
      rst = 1;
      drive(0, 0, 0);
      e = sb.pop_front();
      checks++;
      if ({pc, if_id_instr, if_id_pc_plus4, if_id_valid} !== {e.pc, e.instr, e.pp4, e.valid})
         $display("FAIL after_reset: pc=%h instr=%h pp4=%h v=%b, want pc=%h instr=%h pp4=%h v=%b", pc, if_id_instr, if_id_pc_plus4, if_id_valid, e.pc, e.instr, e.pp4, e.valid);
      else passes++;
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_stall();
      test_redirect();
      test_redirect_stall();
      test_oob();
      test_wrap();
`ifdef FETCH_STATS_EN
      test_stats();
`endif
      test_async_reset();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
